// File: rtl/disparity_argmin.sv
`default_nettype none
// ============================================================================
//  Module   : disparity_argmin
//  Purpose  : Winner-take-all selector. Picks the lowest-SAD disparity out of
//             MAX_DISP candidates and presents it through a one-entry
//             ready/valid output register.
//  Revision : 1.0 - initial release
// ============================================================================
module disparity_argmin #(
  parameter int MAX_DISP  = 16,
  parameter int SAD_WIDTH = 12,
  localparam int DW       = $clog2(MAX_DISP)
) (
  input  logic                 clk_in,
  input  logic                 rst_in,
  input  logic                 clear_in,
  input  logic [SAD_WIDTH-1:0] sad_in,
  input  logic                 sad_valid_in,
  output logic                 sad_ready_out,
  output logic [DW-1:0]        disp_out,
  output logic [SAD_WIDTH-1:0] min_sad_out,
  output logic                 disp_valid_out,
  input  logic                 disp_ready_in
);

  localparam logic [DW-1:0] c_last_idx = DW'(MAX_DISP - 1);

  logic [DW-1:0]        r_cand_cnt;
  logic [SAD_WIDTH-1:0] r_best_sad;
  logic [DW-1:0]        r_best_idx;
  logic [DW-1:0]        r_disp;
  logic [SAD_WIDTH-1:0] r_min_sad;
  logic                 r_valid;

  logic                 w_first;
  logic                 w_last;
  logic                 w_ready;
  logic                 w_accept;
  logic                 w_take;
  logic [SAD_WIDTH-1:0] w_win_sad;
  logic [DW-1:0]        w_win_idx;

  assign w_first = (r_cand_cnt == '0);
  assign w_last  = (r_cand_cnt == c_last_idx);

  // Only the final candidate can stall: it needs a free output register.
  assign w_ready  = !(w_last && r_valid && !disp_ready_in);
  // A sample that coincides with clear_in is dropped along with the pixel.
  assign w_accept = sad_valid_in && w_ready && !clear_in;

  // Strict compare keeps the lowest index on ties.
  assign w_take    = w_first || (sad_in < r_best_sad);
  assign w_win_sad = w_take ? sad_in     : r_best_sad;
  assign w_win_idx = w_take ? r_cand_cnt : r_best_idx;

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      r_cand_cnt <= '0;
      r_best_sad <= '0;
      r_best_idx <= '0;
    end else if (clear_in) begin
      r_cand_cnt <= '0;
    end else if (w_accept) begin
      r_best_sad <= w_win_sad;
      r_best_idx <= w_win_idx;
      r_cand_cnt <= w_last ? '0 : r_cand_cnt + DW'(1);
    end
  end

  // A load on the same edge as a drain takes priority and keeps valid high.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      r_disp    <= '0;
      r_min_sad <= '0;
      r_valid   <= 1'b0;
    end else if (w_accept && w_last) begin
      r_disp    <= w_win_idx;
      r_min_sad <= w_win_sad;
      r_valid   <= 1'b1;
    end else if (r_valid && disp_ready_in) begin
      r_valid   <= 1'b0;
    end
  end

  assign sad_ready_out  = w_ready;
  assign disp_out       = r_disp;
  assign min_sad_out    = r_min_sad;
  assign disp_valid_out = r_valid;

endmodule
`default_nettype wire

// File: tb/tb_disparity_argmin.sv
`default_nettype none
// ============================================================================
//  Module   : tb_disparity_argmin
//  Purpose  : Directed self-checking bench for disparity_argmin (MAX_DISP=4).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_disparity_argmin;

  localparam int MAX_DISP  = 4;
  localparam int SAD_WIDTH = 12;
  localparam int DW        = 2;

  logic                 clk_in = 1'b0;
  logic                 rst_in = 1'b1;
  logic                 clear_in = 1'b0;
  logic [SAD_WIDTH-1:0] sad_in = '0;
  logic                 sad_valid_in = 1'b0;
  logic                 sad_ready_out;
  logic [DW-1:0]        disp_out;
  logic [SAD_WIDTH-1:0] min_sad_out;
  logic                 disp_valid_out;
  logic                 disp_ready_in = 1'b1;

  typedef struct {
    int d;
    int s;
  } res_t;

  res_t q[$];
  int   n_assert = 0;
  int   n_fail   = 0;

  disparity_argmin #(.MAX_DISP(MAX_DISP), .SAD_WIDTH(SAD_WIDTH)) dut (
    .clk_in         (clk_in),
    .rst_in         (rst_in),
    .clear_in       (clear_in),
    .sad_in         (sad_in),
    .sad_valid_in   (sad_valid_in),
    .sad_ready_out  (sad_ready_out),
    .disp_out       (disp_out),
    .min_sad_out    (min_sad_out),
    .disp_valid_out (disp_valid_out),
    .disp_ready_in  (disp_ready_in)
  );

  always #5 clk_in = ~clk_in;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  // Reference winner: strict less-than scan, lowest index wins ties.
  task automatic push_expected(input int a, input int b, input int c, input int d);
    int   v[4];
    res_t r;
    v = '{a, b, c, d};
    r.d = 0;
    r.s = v[0];
    for (int i = 1; i < 4; i++)
      if (v[i] < r.s) begin
        r.d = i;
        r.s = v[i];
      end
    q.push_back(r);
  endtask

  task automatic feed(input int v);
    int w;
    w = 0;
    sad_in       = SAD_WIDTH'(v);
    sad_valid_in = 1'b1;
    #1;
    while (!sad_ready_out && w < 16) begin
      tick();
      w++;
    end
    chk("sad_ready_before_accept", sad_ready_out, 1);
    tick();
  endtask

  task automatic feed_pixel(input int a, input int b, input int c, input int d);
    push_expected(a, b, c, d);
    feed(a);
    feed(b);
    feed(c);
    feed(d);
  endtask

  // Compare outputs against the scoreboard head without consuming it.
  task automatic peek_check(input string tag);
    chk({tag, "_sb_nonempty"}, (q.size() != 0), 1);
    if (q.size() != 0) begin
      chk({tag, "_valid"}, disp_valid_out, 1);
      chk({tag, "_disp"}, disp_out, q[0].d);
      chk({tag, "_min_sad"}, min_sad_out, q[0].s);
    end
  endtask

  task automatic pop_check(input string tag);
    peek_check(tag);
    if (q.size() != 0) void'(q.pop_front());
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset values
    #2;
    chk("rst_valid", disp_valid_out, 0);
    chk("rst_disp", disp_out, 0);
    chk("rst_min_sad", min_sad_out, 0);
    chk("rst_ready", sad_ready_out, 1);
    @(posedge clk_in);
    #1;
    rst_in = 1'b0;
    tick();

    // Basic pixel, result valid for exactly one cycle
    feed_pixel(40, 25, 30, 50);
    sad_valid_in = 1'b0;
    pop_check("basic");
    tick();
    chk("basic_one_cycle", disp_valid_out, 0);

    // Ties and all-ones, back to back with no bubble
    feed_pixel(10, 7, 7, 9);
    pop_check("tie");
    feed_pixel(4095, 4095, 4095, 4095);
    sad_valid_in = 1'b0;
    pop_check("all_ones");
    tick();
    chk("all_ones_drained", disp_valid_out, 0);

    // Backpressure: first result held while second pixel stalls on its last SAD
    disp_ready_in = 1'b0;
    feed_pixel(5, 3, 8, 9);
    sad_valid_in = 1'b0;
    tick();
    peek_check("bp_held");
    push_expected(2, 2, 1, 6);
    feed(2);
    feed(2);
    feed(1);
    sad_in       = 12'd6;
    sad_valid_in = 1'b1;
    #1;
    chk("bp_stall_ready", sad_ready_out, 0);
    tick();
    chk("bp_stall_ready_2", sad_ready_out, 0);
    peek_check("bp_still_held");
    disp_ready_in = 1'b1;
    #1;
    chk("bp_release_ready", sad_ready_out, 1);
    pop_check("bp_drain_first");
    tick();
    sad_valid_in = 1'b0;
    pop_check("bp_second");
    tick();
    chk("bp_empty", disp_valid_out, 0);

    // Simultaneous drain and load with a result already pending
    disp_ready_in = 1'b0;
    feed_pixel(5, 3, 8, 9);
    push_expected(7, 7, 7, 6);
    feed(7);
    feed(7);
    feed(7);
    sad_in        = 12'd6;
    sad_valid_in  = 1'b1;
    disp_ready_in = 1'b1;
    #1;
    pop_check("sim_old");
    tick();
    sad_valid_in = 1'b0;
    pop_check("sim_new");
    tick();
    chk("sim_empty", disp_valid_out, 0);

    // clear_in aborts a partial pixel, including a sample in the clear cycle
    feed(1);
    feed(0);
    clear_in     = 1'b1;
    sad_in       = 12'd0;
    sad_valid_in = 1'b1;
    tick();
    clear_in = 1'b0;
    feed_pixel(9, 8, 7, 6);
    sad_valid_in = 1'b0;
    pop_check("clear");
    tick();

    // Asynchronous reset mid-pixel with a result pending
    disp_ready_in = 1'b0;
    feed_pixel(20, 30, 10, 40);
    feed(1);
    feed(2);
    sad_valid_in = 1'b0;
    #3;
    rst_in = 1'b1;
    #1;
    chk("arst_valid", disp_valid_out, 0);
    chk("arst_disp", disp_out, 0);
    chk("arst_min_sad", min_sad_out, 0);
    chk("arst_ready", sad_ready_out, 1);
    q.delete();
    tick();
    rst_in        = 1'b0;
    disp_ready_in = 1'b1;
    tick();
    feed_pixel(12, 11, 13, 14);
    sad_valid_in = 1'b0;
    pop_check("post_rst");
    tick();
    chk("post_rst_empty", disp_valid_out, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
